// File: rtl/gate_test_pkg.sv
// Shared constants and types for the gate stimulus/response checker.
package gate_test_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned ERR_W   = 3;
    localparam int unsigned VEC_N   = 4;

    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] RUN  = 2'd1;
    localparam logic [STATE_W-1:0] DONE = 2'd2;

    localparam logic [VEC_N-1:0] TT_AND  = 4'b1000;
    localparam logic [VEC_N-1:0] TT_OR   = 4'b1110;
    localparam logic [VEC_N-1:0] TT_XOR  = 4'b0110;
    localparam logic [VEC_N-1:0] TT_NAND = 4'b0111;
    localparam logic [VEC_N-1:0] TT_NOR  = 4'b0001;

    // Result of one sweep, held until the next start or reset
    typedef struct packed {
        logic             pass;
        logic [ERR_W-1:0] err_count;
        logic [VEC_N-1:0] fail_vec;
    } result_t;

endpackage

// File: rtl/gate_stim_checker_if.sv
// Control/status and gate-side signals of the stimulus checker.
interface gate_stim_checker_if;

    logic                              start;
    logic                              x;
    logic                              y;
    logic                              a;
    logic                              busy;
    logic                              done;
    logic                              pass;
    logic [gate_test_pkg::ERR_W-1:0]   err_count;
    logic [gate_test_pkg::VEC_N-1:0]   fail_vec;

    // Environment side: issues start and returns the gate output
    modport master (
        output start, a,
        input  x, y, busy, done, pass, err_count, fail_vec
    );

    // Checker side
    modport slave (
        input  start, a,
        output x, y, busy, done, pass, err_count, fail_vec
    );

endinterface

// File: rtl/hold_timer.sv
// Per-vector hold counter: wraps on terminal count, cleared while idle.
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES == 0) begin : g_bad_hold
        $error("hold_timer: HOLD_CYCLES must be >= 1");
    end

    logic [CNT_W-1:0] cnt_q;

    assign tc_c = en && (cnt_q == LAST);

    // Count while enabled, restart at zero after the last hold cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tc_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gate_stim_checker.sv
// Sweeps a 2-input gate through 00..11, samples its output at the end of
// each hold window and scores it against a truth table.
module gate_stim_checker
    import gate_test_pkg::*;
#(
    parameter int unsigned      HOLD_CYCLES = 5,
    parameter logic [VEC_N-1:0] TRUTH       = TT_OR
) (
    input  logic                clk,
    input  logic                rst_n,
    gate_stim_checker_if.slave  bus
);

    if (HOLD_CYCLES == 0) begin : g_bad_hold
        $error("gate_stim_checker: HOLD_CYCLES must be >= 1");
    end

    logic [STATE_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               x_q, x_d;
    logic               y_q, y_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    result_t            res_q, res_d;
    logic               tc;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q != RUN),
        .en    (state_q == RUN),
        .tc_c  (tc)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    // Next state, stimulus and scoring
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                x_d    = 1'b0;
                y_d    = 1'b0;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (tc) begin
                    if (bus.a != TRUTH[idx_q]) begin
                        res_d.fail_vec[idx_q] = 1'b1;
                        res_d.err_count       = res_q.err_count + ERR_W'(1);
                    end
                    if (idx_q == IDX_W'(3)) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        x_d        = 1'b0;
                        y_d        = 1'b0;
                        res_d.pass = (res_d.err_count == '0);
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        {x_d, y_d} = idx_d;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = res_q.pass;
    assign bus.err_count = res_q.err_count;
    assign bus.fail_vec  = res_q.fail_vec;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed bench: OR/AND gates on a 5-cycle hold, stuck-at-1 on a 1-cycle hold.
module tb_gate_stim_checker;
    import gate_test_pkg::*;

    logic clk;
    logic rst_n;
    int   gate_mode;   // 0: OR gate, 1: AND gate
    int   n_checks;
    int   n_pass;

    gate_stim_checker_if ifa ();
    gate_stim_checker_if ifb ();

    assign ifa.a = (gate_mode == 1) ? (ifa.x & ifa.y) : (ifa.x | ifa.y);
    assign ifb.a = 1'b1;

    gate_stim_checker #(.HOLD_CYCLES(5), .TRUTH(TT_OR)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    gate_stim_checker #(.HOLD_CYCLES(1), .TRUTH(TT_OR)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // {x,y,busy,done,pass,err_count,fail_vec}
    function automatic logic [11:0] snap(input int which);
        if (which == 0)
            return {ifa.x, ifa.y, ifa.busy, ifa.done, ifa.pass, ifa.err_count, ifa.fail_vec};
        else
            return {ifb.x, ifb.y, ifb.busy, ifb.done, ifb.pass, ifb.err_count, ifb.fail_vec};
    endfunction

    task automatic set_start(input int which, input logic v);
        if (which == 0) ifa.start = v;
        else ifb.start = v;
    endtask

    // One start pulse, then observe; k counts clock edges after the start edge
    task automatic sweep(input int which, input int h, input bit restart, input bit stop_at_done,
                         output int first_done, output int n_done);
        int          xy_err;
        logic [11:0] s;
        xy_err     = 0;
        first_done = -1;
        n_done     = 0;
        @(negedge clk);
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        s = snap(which);
        check("start_clear", 32'({s[9], s[7:0]}), 32'h100);
        for (int k = 0; k < 4 * h + 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                set_start(which, restart && (k == h + 2 || k == 3 * h + 2));
            end
            s = snap(which);
            if (k < 4 * h && (s[11:10] != 2'(k / h) || !s[9])) xy_err++;
            if (s[8]) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            if (stop_at_done && s[8]) break;
        end
        set_start(which, 1'b0);
        check("xy_seq", 32'(xy_err), 32'd0);
    endtask

    initial begin
        int          fd;
        int          nd;
        logic [11:0] s;
        n_checks  = 0;
        n_pass    = 0;
        gate_mode = 0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        rst_n     = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_a", 32'(snap(0)), 32'd0);
        check("reset_b", 32'(snap(1)), 32'd0);
        rst_n = 1'b1;

        // Correct OR gate
        sweep(0, 5, 1'b0, 1'b0, fd, nd);
        check("or_done_cycle", 32'(fd), 32'd20);
        check("or_done_count", 32'(nd), 32'd1);
        s = snap(0);
        check("or_result", 32'(s[7:0]), 32'h80);
        check("or_idle", 32'(s[11:8]), 32'd0);

        // AND gate scored against OR table
        gate_mode = 1;
        sweep(0, 5, 1'b0, 1'b0, fd, nd);
        check("and_done_cycle", 32'(fd), 32'd20);
        s = snap(0);
        check("and_fail_vec", 32'(s[3:0]), 32'b0110);
        check("and_err_count", 32'(s[6:4]), 32'd2);
        check("and_pass", 32'(s[7]), 32'd0);
        repeat (5) @(negedge clk);
        check("and_persist", 32'(snap(0)), 32'h026);

        // Start re-pulsed during vectors 1 and 3
        gate_mode = 0;
        sweep(0, 5, 1'b1, 1'b0, fd, nd);
        check("restart_done_cycle", 32'(fd), 32'd20);
        check("restart_done_count", 32'(nd), 32'd1);
        check("restart_pass", 32'(snap(0)), 32'h080);

        // Reset while vector 2 is held
        @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (12) @(negedge clk);
        s = snap(0);
        check("pre_rst_vec2", 32'(s[11:9]), 32'b101);
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'(snap(0)), 32'd0);
        nd = 0;
        repeat (2) begin
            @(negedge clk);
            if (ifa.done) nd++;
        end
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (ifa.done) nd++;
        end
        check("rst_no_done", 32'(nd), 32'd0);
        check("rst_idle", 32'(snap(0)), 32'd0);
        sweep(0, 5, 1'b0, 1'b0, fd, nd);
        check("post_rst_done_cycle", 32'(fd), 32'd20);
        check("post_rst_pass", 32'(snap(0)), 32'h080);

        // HOLD_CYCLES=1, output stuck at 1, back-to-back sweeps
        sweep(1, 1, 1'b0, 1'b1, fd, nd);
        check("h1_done_cycle", 32'(fd), 32'd4);
        check("h1_result", 32'(snap(1)), 32'h111);
        sweep(1, 1, 1'b0, 1'b1, fd, nd);
        check("h1b_done_cycle", 32'(fd), 32'd4);
        check("h1b_result", 32'(snap(1)), 32'h111);
        @(negedge clk);
        check("h1b_persist", 32'(snap(1)), 32'h011);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d checks", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
